// File: rtl/lbuf_rd_timing.sv
// lbuf_rd_timing
//   Output-side video timing generator for a line-buffered scaler. Produces
//   the output raster counters, syncs and DE, plus the line-buffer read
//   address (column/line slot) and the sub-pixel/sub-line repeat phase used
//   to replicate each buffered pixel H_MULT times and each line V_MULT times.
//   Optional frame lock re-aligns the output vertical counter to the input
//   frame.
//
//   Build option: `define LBUF_RD_FRAMELOCK_EN to enable frame lock. Without
//   it, frame_start_tgl is ignored, timing free-runs and lock_adj is 0.
//
// Ports
//   PCLK_out          in   output pixel clock (only clock)
//   reset_n           in   asynchronous active-low reset
//   frame_start_tgl   in   toggles once per input frame (foreign clock domain)
//   hcnt_ext/vcnt_ext out  11b raster counters
//   hcnt_ext_lbuf     out  9b line-buffer read column
//   vcnt_ext_lbuf     out  6b line-buffer read line slot
//   hctr_ext/vctr_ext out  3b horizontal/vertical repeat phase
//   HSYNC_ext/VSYNC_ext out active-low syncs
//   DE_ext            out  active-high data enable
//   lock_adj          out  sticky: a frame lock moved vcnt off its natural value
//
// All outputs are registered together, so every output describes the pixel
// named by hcnt_ext/vcnt_ext in the same cycle. The reset state is itself the
// correct description of pixel (0,0).

module lbuf_rd_timing #(
  parameter int H_TOTAL          = 1344,
  parameter int H_SYNCLEN        = 40,
  parameter int H_BACKPORCH      = 104,
  parameter int H_MULT           = 3,
  parameter int LBUF_WIDTH       = 384,
  parameter int V_TOTAL          = 706,
  parameter int V_SYNCLEN        = 3,
  parameter int V_BACKPORCH      = 25,
  parameter int V_MULT           = 3,
  parameter int LBUF_LINES       = 224,
  parameter int V_LOCK_LINE      = 0,
  parameter int NUM_LINE_BUFFERS = 40
) (
  input  logic        PCLK_out,
  input  logic        reset_n,
  input  logic        frame_start_tgl,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        lock_adj
);

  localparam int H_AVSTART = H_SYNCLEN + H_BACKPORCH;
  localparam int H_ACTIVE  = LBUF_WIDTH * H_MULT;
  localparam int V_AVSTART = V_SYNCLEN + V_BACKPORCH;
  localparam int V_ACTIVE  = LBUF_LINES * V_MULT;

  localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST_C  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNCLEN);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNCLEN);
  localparam logic [10:0] H_AVS_C   = 11'(H_AVSTART);
  localparam logic [10:0] H_AVE_C   = 11'(H_AVSTART + H_ACTIVE);
  localparam logic [10:0] V_AVS_C   = 11'(V_AVSTART);
  localparam logic [10:0] V_AVE_C   = 11'(V_AVSTART + V_ACTIVE);
  localparam logic [10:0] V_LOCK_C  = 11'(V_LOCK_LINE);
  localparam logic [2:0]  H_MULT_M1 = 3'(H_MULT - 1);
  localparam logic [2:0]  V_MULT_M1 = 3'(V_MULT - 1);
  localparam logic [5:0]  NLB_M1    = 6'(NUM_LINE_BUFFERS - 1);

  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [8:0]  hlbuf_q, hlbuf_d;
  logic [5:0]  vlbuf_q, vlbuf_d;
  logic [2:0]  hctr_q, hctr_d, vctr_q, vctr_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic        hwin_d, vwin_d;
  logic        line_end, lock;
  logic [10:0] vnat;

  assign line_end = (hcnt_q == H_LAST_C);
  assign vnat     = (vcnt_q == V_LAST_C) ? 11'd0 : vcnt_q + 11'd1;

`ifdef LBUF_RD_FRAMELOCK_EN
  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the edge-detect
  // delay, so any transition of the synchronised level is one event.
  logic [2:0] sync_q;
  logic       evt, pend_q, pend_d, lock_adj_q, lock_adj_d;

  assign evt  = sync_q[1] ^ sync_q[2];
  assign lock = line_end & pend_q;

  always_comb begin
    pend_d = pend_q;
    if (lock)
      pend_d = 1'b0;
    // An event in the line-end cycle wins over the clear, so it is carried
    // to the following line end rather than lost.
    if (evt)
      pend_d = 1'b1;
    lock_adj_d = lock_adj_q | (lock & (vnat != V_LOCK_C));
  end

  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      pend_q     <= 1'b0;
      lock_adj_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], frame_start_tgl};
      pend_q     <= pend_d;
      lock_adj_q <= lock_adj_d;
    end
  end

  assign lock_adj = lock_adj_q;
`else
  logic unused_tgl;
  assign unused_tgl = frame_start_tgl;
  assign lock       = 1'b0;
  assign lock_adj   = 1'b0;
`endif

  always_comb begin
    hcnt_d = line_end ? 11'd0 : hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (line_end)
      vcnt_d = lock ? V_LOCK_C : vnat;

    hwin_d  = (hcnt_d >= H_AVS_C) && (hcnt_d < H_AVE_C);
    vwin_d  = (vcnt_d >= V_AVS_C) && (vcnt_d < V_AVE_C);
    hsync_d = (hcnt_d >= H_SYNC_C);
    vsync_d = (vcnt_d >= V_SYNC_C);
    de_d    = hwin_d & vwin_d;

    // Horizontal repeat phase restarts at 0 on the first active pixel.
    hctr_d  = 3'd0;
    hlbuf_d = 9'd0;
    if (hwin_d && (hcnt_d != H_AVS_C)) begin
      if (hctr_q == H_MULT_M1) begin
        hctr_d  = 3'd0;
        hlbuf_d = hlbuf_q + 9'd1;
      end else begin
        hctr_d  = hctr_q + 3'd1;
        hlbuf_d = hlbuf_q;
      end
    end

    // Vertical phase changes only at line boundaries; the slot holds its
    // value through blanking.
    vctr_d  = vctr_q;
    vlbuf_d = vlbuf_q;
    if (line_end) begin
      if (vcnt_d == V_AVS_C) begin
        vctr_d  = 3'd0;
        vlbuf_d = 6'd0;
      end else if (vwin_d) begin
        if (vctr_q == V_MULT_M1) begin
          vctr_d  = 3'd0;
          vlbuf_d = (vlbuf_q == NLB_M1) ? 6'd0 : vlbuf_q + 6'd1;
        end else begin
          vctr_d  = vctr_q + 3'd1;
        end
      end else begin
        vctr_d  = 3'd0;
      end
    end
  end

  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hlbuf_q <= '0;
      vlbuf_q <= '0;
      hctr_q  <= '0;
      vctr_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hlbuf_q <= hlbuf_d;
      vlbuf_q <= vlbuf_d;
      hctr_q  <= hctr_d;
      vctr_q  <= vctr_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
    end
  end

  assign hcnt_ext      = hcnt_q;
  assign vcnt_ext      = vcnt_q;
  assign hcnt_ext_lbuf = hlbuf_q;
  assign vcnt_ext_lbuf = vlbuf_q;
  assign hctr_ext      = hctr_q;
  assign vctr_ext      = vctr_q;
  assign HSYNC_ext     = hsync_q;
  assign VSYNC_ext     = vsync_q;
  assign DE_ext        = de_q;

endmodule

// File: tb/tb_lbuf_rd_timing.sv
// Testbench for lbuf_rd_timing, using a scaled-down raster so several frames
// fit in a short run. Works with or without LBUF_RD_FRAMELOCK_EN defined.
`timescale 1ns/1ps
module tb_lbuf_rd_timing;
  localparam int HT = 40, HSL = 4, HBP = 6, HM = 3, LW = 8;
  localparam int VT = 30, VSL = 2, VBP = 3, VM = 2, LL = 10, VLOCK = 0, NLB = 4;
  localparam int HAVS = HSL + HBP, HAVE = HAVS + LW * HM;
  localparam int VAVS = VSL + VBP, VAVE = VAVS + LL * VM;
`ifdef LBUF_RD_FRAMELOCK_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        PCLK_out = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start_tgl = 1'b0;
  logic [10:0] hcnt_ext, vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext, vctr_ext;
  logic        HSYNC_ext, VSYNC_ext, DE_ext, lock_adj;

  lbuf_rd_timing #(
    .H_TOTAL(HT), .H_SYNCLEN(HSL), .H_BACKPORCH(HBP), .H_MULT(HM), .LBUF_WIDTH(LW),
    .V_TOTAL(VT), .V_SYNCLEN(VSL), .V_BACKPORCH(VBP), .V_MULT(VM), .LBUF_LINES(LL),
    .V_LOCK_LINE(VLOCK), .NUM_LINE_BUFFERS(NLB)
  ) dut (
    .PCLK_out(PCLK_out), .reset_n(reset_n), .frame_start_tgl(frame_start_tgl),
    .hcnt_ext(hcnt_ext), .vcnt_ext(vcnt_ext),
    .hcnt_ext_lbuf(hcnt_ext_lbuf), .vcnt_ext_lbuf(vcnt_ext_lbuf),
    .hctr_ext(hctr_ext), .vctr_ext(vctr_ext),
    .HSYNC_ext(HSYNC_ext), .VSYNC_ext(VSYNC_ext), .DE_ext(DE_ext), .lock_adj(lock_adj)
  );

  always #5 PCLK_out = ~PCLK_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int cyc     = 0;

  // Reference: raster position, pending lock, input sample history.
  int m_h = 0, m_v = 0, m_vlb = 0;
  bit m_ladj = 0, m_pend = 0, m_s1 = 0, m_s2 = 0, m_s3 = 0;

  function automatic bit vwin(input int v);
    return (v >= VAVS) && (v < VAVE);
  endfunction

  task automatic model_step();
    bit lk, ev;
    int nat;
    lk = 1'b0;
    if (FL) begin
      lk = m_pend && (m_h == HT - 1);
      ev = (m_s2 != m_s3);
      if (ev) m_pend = 1'b1;
      else if (lk) m_pend = 1'b0;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = frame_start_tgl;
    end
    if (m_h == HT - 1) begin
      m_h = 0;
      nat = (m_v + 1) % VT;
      if (lk) begin
        if (nat != VLOCK) m_ladj = 1'b1;
        m_v = VLOCK;
      end else begin
        m_v = nat;
      end
      if (vwin(m_v)) m_vlb = ((m_v - VAVS) / VM) % NLB;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  always @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      m_h = 0; m_v = 0; m_vlb = 0; m_ladj = 0; m_pend = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
    end else begin
      model_step();
    end
  end

  always @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Per-cycle comparison of every output against the reference.
  always @(negedge PCLK_out) begin
    if (chk_on) begin
      bit hw, vw, e_hs, e_vs, e_de;
      int e_hc, e_hl, e_ht, e_vt;
      hw   = (m_h >= HAVS) && (m_h < HAVE);
      vw   = vwin(m_v);
      e_hs = (m_h >= HSL);
      e_vs = (m_v >= VSL);
      e_de = hw && vw;
      e_ht = hw ? (m_h - HAVS) % HM : 0;
      e_hl = hw ? (m_h - HAVS) / HM : 0;
      e_vt = vw ? (m_v - VAVS) % VM : 0;
      e_hc = m_h;
      n_tests++;
      if (hcnt_ext !== 11'(e_hc) || vcnt_ext !== 11'(m_v) || hcnt_ext_lbuf !== 9'(e_hl) ||
          vcnt_ext_lbuf !== 6'(m_vlb) || hctr_ext !== 3'(e_ht) || vctr_ext !== 3'(e_vt) ||
          HSYNC_ext !== e_hs || VSYNC_ext !== e_vs || DE_ext !== e_de || lock_adj !== m_ladj) begin
        n_fail++;
        $display("FAIL outputs t=%0t got hc=%0d vc=%0d hl=%0d vl=%0d ht=%0d vt=%0d hs=%0b vs=%0b de=%0b la=%0b exp hc=%0d vc=%0d hl=%0d vl=%0d ht=%0d vt=%0d hs=%0b vs=%0b de=%0b la=%0b",
                 $time, hcnt_ext, vcnt_ext, hcnt_ext_lbuf, vcnt_ext_lbuf, hctr_ext, vctr_ext,
                 HSYNC_ext, VSYNC_ext, DE_ext, lock_adj,
                 e_hc, m_v, e_hl, m_vlb, e_ht, e_vt, e_hs, e_vs, e_de, m_ladj);
        if (n_fail >= 100) summary_and_finish();
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge PCLK_out);
      g++;
    end
    pin("at_cyc reached", cyc, n);
  endtask

  task automatic wait_pos(input int v, input int h);
    int g = 0;
    while (!(m_v == v && m_h == h) && g < 3000) begin
      @(negedge PCLK_out);
      g++;
    end
    n_tests++;
    if (!(m_v == v && m_h == h)) begin
      n_fail++;
      $display("FAIL wait_pos timeout: got v=%0d h=%0d expected v=%0d h=%0d", m_v, m_h, v, h);
    end
  endtask

  task automatic next_line();
    int g = 0;
    do begin
      @(negedge PCLK_out);
      g++;
    end while (m_h != 0 && g < 100);
    pin("next_line reached", m_h, 0);
  endtask

  initial begin
    @(posedge PCLK_out);
    chk_on = 1'b1;
    @(negedge PCLK_out);
    @(negedge PCLK_out);
    pin("reset hcnt", hcnt_ext, 0);
    pin("reset HSYNC", HSYNC_ext, 0);
    pin("reset VSYNC", VSYNC_ext, 0);
    pin("reset DE", DE_ext, 0);
    reset_n = 1'b1;

    // Directed literal expectations on the scaled raster (cycle n -> h=n%40, v=n/40).
    at_cyc(1);    pin("first hcnt", hcnt_ext, 1); pin("first vcnt", vcnt_ext, 0);
    at_cyc(3);    pin("hsync h3", HSYNC_ext, 0);
    at_cyc(4);    pin("hsync h4", HSYNC_ext, 1);
    at_cyc(41);   pin("vsync v1", VSYNC_ext, 0);
    at_cyc(80);   pin("vsync v2", VSYNC_ext, 1);
    at_cyc(209);  pin("de before start", DE_ext, 0);
    at_cyc(210);  pin("de start", DE_ext, 1); pin("hctr start", hctr_ext, 0);
                  pin("hlbuf start", hcnt_ext_lbuf, 0); pin("vlbuf start", vcnt_ext_lbuf, 0);
    at_cyc(233);  pin("hctr last", hctr_ext, 2); pin("hlbuf last", hcnt_ext_lbuf, 7);
    at_cyc(234);  pin("de end", DE_ext, 0); pin("hlbuf end", hcnt_ext_lbuf, 0);
    at_cyc(500);  pin("vctr line12", vctr_ext, 1); pin("vlbuf line12", vcnt_ext_lbuf, 3);
    at_cyc(540);  pin("vlbuf wrap", vcnt_ext_lbuf, 0); pin("vctr line13", vctr_ext, 0);
    at_cyc(1020); pin("vlbuf hold", vcnt_ext_lbuf, 1); pin("de vblank", DE_ext, 0);
    at_cyc(1220); pin("vcnt wrap", vcnt_ext, 0); pin("vlbuf hold next", vcnt_ext_lbuf, 1);
    at_cyc(1420); pin("vlbuf restart", vcnt_ext_lbuf, 0);

    // Mid-line toggle: lock on this line end.
    wait_pos(15, 20);
    frame_start_tgl = ~frame_start_tgl;
    next_line();
    pin("lock vcnt", vcnt_ext, FL ? 0 : 16);
    pin("lock_adj set", lock_adj, FL ? 1 : 0);

    // Event detected in the line-end cycle applies one line later.
    wait_pos(10, 37);
    frame_start_tgl = ~frame_start_tgl;
    next_line();
    pin("late evt next line", vcnt_ext, 11);
    next_line();
    pin("late evt lock", vcnt_ext, FL ? 0 : 12);

    // Two toggles in one line: a single lock.
    wait_pos(8, 5);
    frame_start_tgl = ~frame_start_tgl;
    wait_pos(8, 15);
    frame_start_tgl = ~frame_start_tgl;
    next_line();
    pin("double evt lock", vcnt_ext, FL ? 0 : 9);
    next_line();
    pin("double evt single", vcnt_ext, FL ? 1 : 10);
    pin("lock_adj sticky", lock_adj, FL ? 1 : 0);

    // Asynchronous reset mid-frame.
    wait_pos(14, 20);
    #2 reset_n = 1'b0;
    #1;
    pin("async rst hcnt", hcnt_ext, 0);
    pin("async rst vcnt", vcnt_ext, 0);
    pin("async rst hlbuf", hcnt_ext_lbuf, 0);
    pin("async rst vlbuf", vcnt_ext_lbuf, 0);
    pin("async rst HSYNC", HSYNC_ext, 0);
    pin("async rst DE", DE_ext, 0);
    pin("async rst lock_adj", lock_adj, 0);
    @(negedge PCLK_out);
    @(negedge PCLK_out);
    reset_n = 1'b1;
    @(negedge PCLK_out);
    pin("restart hcnt", hcnt_ext, 1);
    pin("restart vcnt", vcnt_ext, 0);

    // Randomized toggles with occasional short reset pulses.
    for (int i = 0; i < 20000; i++) begin
      @(negedge PCLK_out);
      if ($urandom_range(0, 149) == 0) frame_start_tgl = ~frame_start_tgl;
      if ($urandom_range(0, 7999) == 0) begin
        #3 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end
    @(negedge PCLK_out);
    summary_and_finish();
  end
endmodule

// File: doc/lbuf_rd_timing.md
LBUF_RD_TIMING -- requirements
Module: lbuf_rd_timing

Interface
REQ-001 Parameter H_TOTAL, 1344, output clocks per line.
REQ-002 Parameter H_SYNCLEN, 40; H_BACKPORCH, 104. Active video start H_AVSTART = H_SYNCLEN+H_BACKPORCH = 144.
REQ-003 Parameter H_MULT, 3, output pixels per line-buffer pixel, legal 1..5. H_ACTIVE = 384*H_MULT.
REQ-004 Parameter V_TOTAL, 706; V_SYNCLEN, 3; V_BACKPORCH, 25. V_AVSTART = 28.
REQ-005 Parameter V_MULT, 3, output lines per line-buffer line, legal 1..5. V_ACTIVE = 224*V_MULT.
REQ-006 Parameter V_LOCK_LINE, 0, vcnt value forced on frame lock; NUM_LINE_BUFFERS, 40.
REQ-007 Reset reset_n, asynchronous, active-low; clock PCLK_out.
REQ-008 PCLK_out  in  1  output pixel clock, sole clock of the block.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 frame_start_tgl  in  1  toggles once per input frame; PCLK_in domain, asynchronous to PCLK_out.
REQ-011 hcnt_ext, vcnt_ext  out  11 each  horizontal and vertical output counters.
REQ-012 hcnt_ext_lbuf  out  9  line-buffer read column, 0..383.
REQ-013 vcnt_ext_lbuf  out  6  line-buffer read line slot, 0..NUM_LINE_BUFFERS-1.
REQ-014 hctr_ext, vctr_ext  out  3 each  sub-pixel and sub-line repeat phase.
REQ-015 HSYNC_ext, VSYNC_ext, DE_ext  out  1 each  syncs active-low, DE active-high.
REQ-016 lock_adj  out  1  sticky; set when a frame lock changed vcnt from its natural next value.

Function
REQ-017 The block SHALL register all outputs on PCLK_out, mutually cycle-aligned: each output describes the same pixel as the hcnt_ext value in that cycle.
REQ-018 hcnt_ext SHALL count 0..H_TOTAL-1 and wrap to 0. On the wrap, vcnt_ext SHALL count 0..V_TOTAL-1 and wrap to 0.
REQ-019 HSYNC_ext SHALL be 0 when hcnt_ext < H_SYNCLEN, otherwise 1. VSYNC_ext SHALL be 0 when vcnt_ext < V_SYNCLEN, otherwise 1.
REQ-020 DE_ext SHALL be 1 when H_AVSTART <= hcnt_ext < H_AVSTART+H_ACTIVE and V_AVSTART <= vcnt_ext < V_AVSTART+V_ACTIVE.
REQ-021 hctr_ext SHALL be 0 at hcnt_ext = H_AVSTART and step 0..H_MULT-1 cyclically across the horizontal active window.
- hcnt_ext_lbuf SHALL increment when hctr_ext wraps.
- Outside the window, hctr_ext and hcnt_ext_lbuf SHALL be 0.
REQ-022 vctr_ext SHALL be 0 on line V_AVSTART and step 0..V_MULT-1 per line in the vertical active window; 0 outside it.
REQ-023 vcnt_ext_lbuf SHALL be 0 at the start of the vertical active window.
- Increment when vctr_ext wraps.
- Wrap from NUM_LINE_BUFFERS-1 to 0.
- Hold its value outside the window.
REQ-024 frame_start_tgl SHALL pass through a 2-flop synchroniser followed by an edge detector (any transition = one event).
REQ-025 Each detected event SHALL set a pending flag one cycle after detection.
REQ-026 At a line end (hcnt_ext = H_TOTAL-1) with the pending flag set, the block SHALL:
- load vcnt_ext with V_LOCK_LINE instead of incrementing it;
- clear the pending flag;
- leave hcnt_ext wrapping normally.
REQ-027 An event detected in the line-end cycle itself SHALL take effect at the following line end. Multiple events before one line end SHALL cause a single lock.
REQ-028 lock_adj SHALL set when a lock loads a value differing from the natural next vcnt. Only reset clears it.

Reset
REQ-029 While reset_n = 0 the block SHALL drive:
- hcnt_ext, vcnt_ext, hcnt_ext_lbuf, vcnt_ext_lbuf, hctr_ext, vctr_ext = 0;
- HSYNC_ext = VSYNC_ext = 0, DE_ext = 0, lock_adj = 0;
- pending flag and synchroniser flops cleared.
REQ-030 After reset release, counting SHALL begin from hcnt_ext = vcnt_ext = 0 on the first PCLK_out edge. A reset mid-frame SHALL abort the frame with no residual state.

Configuration
REQ-031 Macro LBUF_RD_FRAMELOCK_EN:
- Defined: REQ-024..REQ-028 are implemented.
- Undefined: frame_start_tgl is ignored, the timing free-runs, and lock_adj is tied to 0.

Verification
REQ-032 Reset, then free-run 706 lines: HSYNC_ext low for hcnt 0..39, DE_ext high for hcnt 144..1295 on lines 28..699, 1152*672 DE cycles per frame.
REQ-033 Active line 28: hcnt_ext_lbuf = 0,0,0,1,1,1,... with hctr_ext = 0,1,2,0,1,2,... and hcnt_ext_lbuf = 383 at hcnt 1295.
REQ-034 Over the active frame, vcnt_ext_lbuf steps every 3 lines, 0..39 then wraps to 0 (line 148), ending at 223 mod 40 = 23.
REQ-035 With LBUF_RD_FRAMELOCK_EN defined, toggle frame_start_tgl when vcnt = 300 mid-line: the next line has vcnt_ext = 0 and lock_adj = 1. A toggle arriving exactly at hcnt = 1343 applies one line later.
REQ-036 Toggle frame_start_tgl twice within one line: exactly one lock occurs. With the macro undefined, the same stimulus leaves the vcnt sequence unchanged and lock_adj = 0.
REQ-037 Assert reset_n mid-frame at vcnt = 400: all outputs read 0 asynchronously, and after release the frame restarts at hcnt = vcnt = 0.
